// File: rtl/div_share_ctrl.sv
// div_share_ctrl
// Shares one 32-bit unsigned divider between two requesters.
// Requests are granted round-robin. Each granted operation clears the divider,
// launches it and then waits for completion, bounded by TIMEOUT cycles.
// Divide-by-zero is answered directly and never reaches the datapath.
module div_share_ctrl #(
   parameter int TIMEOUT = 40
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req0_valid,
   output logic        req0_ready,
   input  logic [31:0] req0_dvnd,
   input  logic [31:0] req0_dvsr,
   input  logic        req1_valid,
   output logic        req1_ready,
   input  logic [31:0] req1_dvnd,
   input  logic [31:0] req1_dvsr,
   output logic        rsp_valid,
   output logic        rsp_id,
   output logic [31:0] rsp_q,
   output logic [31:0] rsp_r,
   output logic [1:0]  rsp_err,
   output logic        busy,
   output logic        div_rst,
   output logic        div_run,
   output logic [31:0] div_dvnd,
   output logic [31:0] div_dvsr,
   input  logic [31:0] div_q,
   input  logic [31:0] div_r,
   input  logic        div_rdy
);

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_CLR  = 3'd1,
      ST_RUN  = 3'd2,
      ST_WAIT = 3'd3,
      ST_DONE = 3'd4,
      ST_ZERO = 3'd5
   } state_t;

   // Last counter value still spent waiting; reaching it without div_rdy aborts.
   localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

   state_t      state_r;
   state_t      next_state_s;
   logic        last_grant_r;
   logic        id_r;
   logic [7:0]  tmo_cnt_r;
   logic        gnt_valid_s;
   logic        gnt_id_s;
   logic [31:0] gnt_dvnd_s;
   logic [31:0] gnt_dvsr_s;
   logic        accept_s;
   logic        rdy_hit_s;
   logic        tmo_hit_s;

   // Round-robin pick: a lone requester wins, on contention the one not served last
   always_comb begin
      gnt_valid_s = 1'b0;
      gnt_id_s    = 1'b0;
      if (req0_valid && req1_valid) begin
         gnt_valid_s = 1'b1;
         gnt_id_s    = ~last_grant_r;
      end else if (req0_valid) begin
         gnt_valid_s = 1'b1;
         gnt_id_s    = 1'b0;
      end else if (req1_valid) begin
         gnt_valid_s = 1'b1;
         gnt_id_s    = 1'b1;
      end else begin
         gnt_valid_s = 1'b0;
         gnt_id_s    = 1'b0;
      end
   end

   assign gnt_dvnd_s = gnt_id_s ? req1_dvnd : req0_dvnd;
   assign gnt_dvsr_s = gnt_id_s ? req1_dvsr : req0_dvsr;
   assign accept_s   = (state_r == ST_IDLE) && gnt_valid_s && !rst;

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= next_state_s;
      end
   end

   // Next-state decode and per-state strobes; div_rst also follows rst directly
   always_comb begin
      next_state_s = state_r;
      req0_ready   = 1'b0;
      req1_ready   = 1'b0;
      div_rst      = rst;
      div_run      = 1'b0;
      rsp_valid    = 1'b0;
      busy         = 1'b1;
      rdy_hit_s    = 1'b0;
      tmo_hit_s    = 1'b0;
      case (state_r)
         ST_IDLE: begin
            busy = 1'b0;
            if (accept_s) begin
               req0_ready = ~gnt_id_s;
               req1_ready = gnt_id_s;
               if (gnt_dvsr_s == 32'd0) begin
                  next_state_s = ST_ZERO;
               end else begin
                  next_state_s = ST_CLR;
               end
            end else begin
               next_state_s = ST_IDLE;
            end
         end
         ST_CLR: begin
            div_rst      = 1'b1;
            next_state_s = ST_RUN;
         end
         ST_RUN: begin
            div_run      = 1'b1;
            next_state_s = ST_WAIT;
         end
         ST_WAIT: begin
            // a completion on the last counted cycle still beats the timeout
            if (div_rdy) begin
               rdy_hit_s    = 1'b1;
               next_state_s = ST_DONE;
            end else if (tmo_cnt_r == TO_LAST) begin
               tmo_hit_s    = 1'b1;
               next_state_s = ST_DONE;
            end else begin
               next_state_s = ST_WAIT;
            end
         end
         ST_DONE: begin
            rsp_valid    = 1'b1;
            next_state_s = ST_IDLE;
         end
         ST_ZERO: begin
            rsp_valid    = 1'b1;
            next_state_s = ST_IDLE;
         end
         default: begin
            busy         = 1'b0;
            next_state_s = ST_IDLE;
         end
      endcase
   end

   // Latch operands, owner and arbitration history on acceptance
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div_dvnd     <= 32'd0;
         div_dvsr     <= 32'd0;
         id_r         <= 1'b0;
         last_grant_r <= 1'b1;
      end else if (accept_s) begin
         div_dvnd     <= gnt_dvnd_s;
         div_dvsr     <= gnt_dvsr_s;
         id_r         <= gnt_id_s;
         last_grant_r <= gnt_id_s;
      end
   end

   // Timeout counter: cleared at launch, counts WAIT cycles without completion
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tmo_cnt_r <= 8'd0;
      end else if (state_r == ST_RUN) begin
         tmo_cnt_r <= 8'd0;
      end else if ((state_r == ST_WAIT) && !div_rdy) begin
         tmo_cnt_r <= tmo_cnt_r + 8'd1;
      end
   end

   // Response registers; they hold until the next response is produced
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rsp_q   <= 32'd0;
         rsp_r   <= 32'd0;
         rsp_err <= 2'd0;
         rsp_id  <= 1'b0;
      end else if (accept_s && (gnt_dvsr_s == 32'd0)) begin
         rsp_q   <= 32'hFFFF_FFFF;
         rsp_r   <= gnt_dvnd_s;
         rsp_err <= 2'd1;
         rsp_id  <= gnt_id_s;
      end else if (rdy_hit_s) begin
         rsp_q   <= div_q;
         rsp_r   <= div_r;
         rsp_err <= 2'd0;
         rsp_id  <= id_r;
      end else if (tmo_hit_s) begin
         rsp_q   <= 32'd0;
         rsp_r   <= 32'd0;
         rsp_err <= 2'd2;
         rsp_id  <= id_r;
      end
   end

endmodule

// File: tb/tb_div_share_ctrl.sv
// tb_div_share_ctrl
// Bench for div_share_ctrl: directed scenarios followed by randomized traffic.
// A transaction-level model predicts every output each cycle from the
// acceptance time, the operands and the divider's completion delay.
`timescale 1ns/1ps
module tb_div_share_ctrl;
   localparam int TMO = 40;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        req0_valid = 1'b0;
   logic        req1_valid = 1'b0;
   logic [31:0] req0_dvnd = 32'd0;
   logic [31:0] req0_dvsr = 32'd0;
   logic [31:0] req1_dvnd = 32'd0;
   logic [31:0] req1_dvsr = 32'd0;
   logic        req0_ready, req1_ready, rsp_valid, rsp_id, busy, div_rst, div_run;
   logic [31:0] rsp_q, rsp_r, div_dvnd, div_dvsr, div_q, div_r;
   logic [1:0]  rsp_err;
   logic        div_rdy = 1'b0;

   int n_checks = 0;
   int n_errs   = 0;
   int force_dly = -1;
   bit mdl_en = 1'b0;

   div_share_ctrl #(.TIMEOUT(TMO)) dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_dvnd(req0_dvnd), .req0_dvsr(req0_dvsr),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_dvnd(req1_dvnd), .req1_dvsr(req1_dvsr),
      .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_q(rsp_q), .rsp_r(rsp_r), .rsp_err(rsp_err),
      .busy(busy), .div_rst(div_rst), .div_run(div_run), .div_dvnd(div_dvnd), .div_dvsr(div_dvsr),
      .div_q(div_q), .div_r(div_r), .div_rdy(div_rdy)
   );

   always #5 clk = ~clk;

   // ---------------- reference model state ----------------
   bit          m_busy = 1'b0, m_last = 1'b1, m_id = 1'b0, m_rid = 1'b0;
   int          m_k = 0, m_d = 1, lat;
   logic [31:0] m_a = 32'd0, m_b = 32'd0, m_q = 32'd0, m_r = 32'd0;
   logic [1:0]  m_err = 2'd0;
   bit          e_r0, e_r1, e_v, e_drst, e_drun, e_busy, g;
   logic [31:0] e_a, e_b;

   function automatic int pick_delay();
      int s;
      s = $urandom_range(0, 9);
      if (s == 0) return 1000;          // divider never finishes
      else if (s == 1) return TMO;      // finishes on the very last wait cycle
      else if (s == 2) return TMO + 1;  // one cycle too late
      else return $urandom_range(1, 12);
   endfunction

   // ---------------- divider model: completes d WAIT cycles after div_run ----------------
   logic [31:0] dm_a = 32'd0, dm_b = 32'd1, dm_jq = 32'd0, dm_jr = 32'd0;
   int          dm_cnt = 0;
   bit          dm_arm = 1'b0;
   always @(posedge clk) begin
      dm_jq <= $urandom;
      dm_jr <= $urandom;
      if (div_rst === 1'b1) begin
         div_rdy <= 1'b0; dm_arm <= 1'b0; dm_cnt <= 0;
      end else if (div_run === 1'b1) begin
         dm_a <= div_dvnd; dm_b <= div_dvsr; dm_arm <= 1'b1; dm_cnt <= 1;
         div_rdy <= (m_d == 1);
      end else if (dm_arm && !div_rdy) begin
         dm_cnt <= dm_cnt + 1;
         if (dm_cnt + 1 == m_d) div_rdy <= 1'b1;
      end
   end
   assign div_q = (div_rdy && dm_b != 32'd0) ? dm_a / dm_b : dm_jq;
   assign div_r = (div_rdy && dm_b != 32'd0) ? dm_a % dm_b : dm_jr;

   // ---------------- per-cycle model step and compare ----------------
   always @(negedge clk) begin
      if (mdl_en) begin
         e_r0 = 1'b0; e_r1 = 1'b0; e_v = 1'b0; e_drst = 1'b0; e_drun = 1'b0;
         if (rst) begin
            m_busy = 1'b0; m_last = 1'b1; m_id = 1'b0; m_k = 0; m_a = 32'd0; m_b = 32'd0;
            m_q = 32'd0; m_r = 32'd0; m_rid = 1'b0; m_err = 2'd0;
            e_drst = 1'b1;
         end
         e_busy = m_busy && !rst;
         e_a = m_a;
         e_b = m_b;
         if (!rst && !m_busy) begin
            if (req0_valid || req1_valid) begin
               g = (req0_valid && req1_valid) ? !m_last : req1_valid;
               e_r0 = !g; e_r1 = g;
               m_busy = 1'b1; m_k = 0; m_id = g; m_last = g;
               m_a = g ? req1_dvnd : req0_dvnd;
               m_b = g ? req1_dvsr : req0_dvsr;
               m_d = (force_dly >= 0) ? force_dly : pick_delay();
            end
         end else if (!rst) begin
            m_k++;
            if (m_b == 32'd0) begin
               e_v = 1'b1; m_q = 32'hFFFF_FFFF; m_r = m_a; m_err = 2'd1; m_rid = m_id; m_busy = 1'b0;
            end else begin
               e_drst = (m_k == 1);
               e_drun = (m_k == 2);
               lat = 3 + ((m_d < TMO) ? m_d : TMO);
               if (m_k == lat) begin
                  e_v = 1'b1; m_rid = m_id; m_busy = 1'b0;
                  if (m_d <= TMO) begin
                     m_q = m_a / m_b; m_r = m_a % m_b; m_err = 2'd0;
                  end else begin
                     m_q = 32'd0; m_r = 32'd0; m_err = 2'd2;
                  end
               end
            end
         end
         n_checks++;
         if ({req0_ready, req1_ready, rsp_valid, busy, div_rst, div_run} !== {e_r0, e_r1, e_v, e_busy, e_drst, e_drun}
             || (rsp_q !== m_q) || (rsp_r !== m_r) || (rsp_id !== m_rid) || (rsp_err !== m_err)
             || (div_dvnd !== e_a) || (div_dvsr !== e_b)) begin
            n_errs++;
            $display("FAIL cycle_model t=%0t: got rdy0,rdy1,val,busy,drst,drun=%b q=%h r=%h id=%b err=%0d op=%h/%h ; expected %b q=%h r=%h id=%b err=%0d op=%h/%h",
                     $time, {req0_ready, req1_ready, rsp_valid, busy, div_rst, div_run}, rsp_q, rsp_r, rsp_id, rsp_err,
                     div_dvnd, div_dvsr, {e_r0, e_r1, e_v, e_busy, e_drst, e_drun}, m_q, m_r, m_rid, m_err, e_a, e_b);
         end
      end
   end

   // ---------------- helpers ----------------
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errs++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input bit id, input bit v, input logic [31:0] a, input logic [31:0] b);
      if (id) begin req1_valid = v; req1_dvnd = a; req1_dvsr = b; end
      else    begin req0_valid = v; req0_dvnd = a; req0_dvsr = b; end
   endtask

   // present one request, hold it until ready, drop it; returns in the cycle after acceptance
   task automatic issue(input bit id, input logic [31:0] a, input logic [31:0] b);
      bit got;
      got = 1'b0;
      @(posedge clk); #1;
      drive(id, 1'b1, a, b);
      for (int i = 0; i < 300 && !got; i++) begin
         @(negedge clk);
         got = id ? req1_ready : req0_ready;
      end
      if (!got) begin
         n_checks++; n_errs++;
         $display("FAIL issue_wait: requester %0d not accepted within 300 cycles", id);
      end
      @(posedge clk); #1;
      if (id) req1_valid = 1'b0; else req0_valid = 1'b0;
   endtask

   task automatic wait_rsp(output int cyc);
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
      end while (!rsp_valid && cyc < 300);
      if (!rsp_valid) begin
         n_checks++; n_errs++;
         $display("FAIL rsp_wait: got no rsp_valid expected one within %0d cycles", cyc);
      end
      #1;
   endtask

   task automatic wait_ready(output int who);
      who = -1;
      for (int i = 0; i < 300 && who < 0; i++) begin
         @(negedge clk);
         if (req0_ready) who = 0;
         else if (req1_ready) who = 1;
      end
      if (who < 0) begin
         n_checks++; n_errs++;
         $display("FAIL ready_wait: got no grant expected one within 300 cycles");
      end
   endtask

   task automatic new_op(input bit id);
      logic [31:0] a, b;
      int s;
      a = $urandom;
      s = $urandom_range(0, 7);
      case (s)
         0: b = 32'd0;
         1: b = $urandom;
         2: b = 32'd1;
         3: begin b = $urandom_range(1, 20); a = $urandom_range(0, 100); end
         default: b = $urandom_range(1, 1000);
      endcase
      drive(id, 1'b1, a, b);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int c, who, pulses;
      bit s0, s1;

      // reset pulse starting mid-cycle
      #2 rst = 1'b1; mdl_en = 1'b1;
      #1 chk("rst_div_rst", {31'd0, div_rst}, 32'd1);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      @(posedge clk); @(posedge clk); #1 rst = 1'b0;

      // single request 100/7
      force_dly = 5;
      issue(1'b0, 32'd100, 32'd7);
      @(negedge clk);
      chk("t1_clr_div_rst", {31'd0, div_rst}, 32'd1);
      @(negedge clk);
      chk("t1_run_div_run", {31'd0, div_run}, 32'd1);
      chk("t1_run_div_rst", {31'd0, div_rst}, 32'd0);
      wait_rsp(c);
      chk("t1_latency", c, 32'd6);
      chk("t1_id", {31'd0, rsp_id}, 32'd0);
      chk("t1_q", rsp_q, 32'd14);
      chk("t1_r", rsp_r, 32'd2);
      chk("t1_err", {30'd0, rsp_err}, 32'd0);
      chk("t1_model_q", m_q, 32'd14);

      // divide by zero from requester 1
      issue(1'b1, 32'h1234, 32'd0);
      @(negedge clk); #1;
      chk("zero_valid", {31'd0, rsp_valid}, 32'd1);
      chk("zero_q", rsp_q, 32'hFFFF_FFFF);
      chk("zero_r", rsp_r, 32'h1234);
      chk("zero_err", {30'd0, rsp_err}, 32'd1);
      chk("zero_id", {31'd0, rsp_id}, 32'd1);
      chk("zero_div_strobes", {30'd0, div_run, div_rst}, 32'd0);
      chk("zero_model_r", m_r, 32'h1234);

      // timeout: divider never completes
      force_dly = 1000;
      issue(1'b0, 32'd50, 32'd5);
      wait_rsp(c);
      chk("tmo_latency", c, 32'(TMO + 3));
      chk("tmo_err", {30'd0, rsp_err}, 32'd2);
      chk("tmo_q", rsp_q, 32'd0);
      chk("tmo_r", rsp_r, 32'd0);
      chk("tmo_model_err", {30'd0, m_err}, 32'd2);
      force_dly = 2;
      issue(1'b1, 32'd77, 32'd7);
      wait_rsp(c);
      chk("after_tmo_q", rsp_q, 32'd11);
      chk("after_tmo_id", {31'd0, rsp_id}, 32'd1);

      // completion on the last counted wait cycle
      force_dly = TMO;
      issue(1'b1, 32'd1000, 32'd10);
      wait_rsp(c);
      chk("last_cnt_latency", c, 32'(TMO + 3));
      chk("last_cnt_err", {30'd0, rsp_err}, 32'd0);
      chk("last_cnt_q", rsp_q, 32'd100);

      // reset in the middle of WAIT
      force_dly = 1000;
      issue(1'b0, 32'd500, 32'd3);
      repeat (6) @(negedge clk);
      @(posedge clk); #2 rst = 1'b1;
      @(negedge clk); #1;
      chk("midrst_busy", {31'd0, busy}, 32'd0);
      chk("midrst_q_cleared", rsp_q, 32'd0);
      chk("midrst_div_rst", {31'd0, div_rst}, 32'd1);
      @(posedge clk); #1 rst = 1'b0;
      pulses = 0;
      repeat (60) begin
         @(negedge clk);
         if (rsp_valid) pulses++;
      end
      chk("midrst_no_rsp", pulses, 32'd0);
      force_dly = 4;
      issue(1'b1, 32'd1000, 32'd33);
      wait_rsp(c);
      chk("midrst_fresh_q", rsp_q, 32'd30);
      chk("midrst_fresh_r", rsp_r, 32'd10);

      // contention from reset: both requesters valid
      force_dly = 3;
      @(posedge clk); #1;
      rst = 1'b1;
      drive(1'b0, 1'b1, 32'hFFFF_FFFF, 32'h10);
      drive(1'b1, 1'b1, 32'd9, 32'd3);
      @(posedge clk); #1 rst = 1'b0;
      wait_ready(who);
      chk("cont_grant1", who, 32'd0);
      @(posedge clk); #1 drive(1'b0, 1'b1, 32'd20, 32'd4);
      wait_rsp(c);
      chk("cont_rsp1_id", {31'd0, rsp_id}, 32'd0);
      chk("cont_rsp1_q", rsp_q, 32'h0FFF_FFFF);
      chk("cont_rsp1_r", rsp_r, 32'hF);
      wait_ready(who);
      chk("cont_grant2", who, 32'd1);
      @(posedge clk); #1 req1_valid = 1'b0;
      wait_rsp(c);
      chk("cont_rsp2_id", {31'd0, rsp_id}, 32'd1);
      chk("cont_rsp2_q", rsp_q, 32'd3);
      chk("cont_rsp2_r", rsp_r, 32'd0);
      wait_ready(who);
      chk("cont_grant3", who, 32'd0);
      @(posedge clk); #1 req0_valid = 1'b0;
      wait_rsp(c);
      chk("cont_rsp3_q", rsp_q, 32'd5);

      // randomized traffic with occasional resets
      force_dly = -1;
      for (int i = 0; i < 4000; i++) begin
         @(negedge clk);
         s0 = req0_ready;
         s1 = req1_ready;
         @(posedge clk); #1;
         if (rst) rst = 1'b0;
         else if ($urandom_range(0, 599) == 0) rst = 1'b1;
         if (s0) begin
            if ($urandom_range(0, 2) == 0) req0_valid = 1'b0; else new_op(1'b0);
         end else if (!req0_valid && $urandom_range(0, 3) == 0) begin
            new_op(1'b0);
         end
         if (s1) begin
            if ($urandom_range(0, 2) == 0) req1_valid = 1'b0; else new_op(1'b1);
         end else if (!req1_valid && $urandom_range(0, 3) == 0) begin
            new_op(1'b1);
         end
      end
      @(posedge clk); #1;
      rst = 1'b0;
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      repeat (100) @(negedge clk);

      $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
      $finish;
   end

endmodule

// File: doc/div_share_ctrl.md
Name: div_share_ctrl

Overview:
- Sequencer and arbiter that shares one 32-bit unsigned divider datapath between two requesters.
- Accepts divide requests with a valid/ready handshake and grants them round-robin.
- Configures the divider for each operation: clears it, launches it, then waits for completion.
- Returns quotient and remainder tagged with the requester ID. Handles divide-by-zero and divider timeout without using the datapath.

Parameters:
- TIMEOUT, 40: cycles spent in WAIT before the operation is aborted. Legal range 34..255.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous active-high reset
- req0_valid  in  1  requester 0 has an operation pending
- req0_ready  out  1  requester 0 operation accepted this cycle
- req0_dvnd  in  32  requester 0 dividend
- req0_dvsr  in  32  requester 0 divisor
- req1_valid, req1_ready, req1_dvnd, req1_dvsr  same as requester 0, for requester 1
- rsp_valid  out  1  one-cycle response strobe
- rsp_id  out  1  requester that owns the response
- rsp_q  out  32  quotient
- rsp_r  out  32  remainder
- rsp_err  out  2  0 = ok, 1 = divide-by-zero, 2 = timeout
- busy  out  1  high in any state other than IDLE
- div_rst  out  1  divider reset
- div_run  out  1  divider start
- div_dvnd  out  32  operand register to the divider
- div_dvsr  out  32  operand register to the divider
- div_q  in  32  divider quotient
- div_r  in  32  divider remainder
- div_rdy  in  1  divider done, level signal

Behaviour:
- **Reset.** While rst is high, div_rst = 1 combinationally. All other outputs and registers are 0: state = IDLE, last_grant = 1 (so requester 0 wins first), timeout counter = 0.
- **Reset release.** The divider sees div_rst during reset and for no extra cycle after it.
- **Reset mid-operation.** An in-flight operation is dropped and no response is produced.
- **States.** IDLE, CLR, RUN, WAIT, DONE, ZERO.
- **IDLE arbitration.** If any reqN_valid is high, grant one:
  - If only one requester is valid, grant it.
  - If both are valid, grant the one that is not last_grant.
- **Acceptance.** The accepted cycle is IDLE with a grant.
  - reqN_ready = 1 for that cycle only.
  - Operands are latched into div_dvnd/div_dvsr, the ID is latched, and last_grant is updated.
  - If the latched divisor is 0, go to ZERO; otherwise go to CLR.
- **ready is combinational from IDLE and valid.** A requester holds valid and operands stable until it sees ready.
- **CLR.** div_rst = 1 for one cycle; go to RUN.
- **RUN.** div_run = 1 for one cycle; clear the timeout counter; go to WAIT.
- **Operand stability.** div_dvnd/div_dvsr stay constant from acceptance until the state returns to IDLE.
- **WAIT.**
  - div_rdy is sampled every cycle; div_run = 0.
  - When div_rdy = 1: capture div_q/div_r into rsp_q/rsp_r, set rsp_err = 0, go to DONE.
  - Otherwise the counter increments. When the counter reaches TIMEOUT-1 with div_rdy still 0: rsp_q = rsp_r = 0, rsp_err = 2, go to DONE.
  - div_rdy and timeout in the same cycle: div_rdy wins.
- **DONE.** rsp_valid = 1 with rsp_id; go to IDLE. A new request cannot be accepted in DONE; the earliest is the next IDLE cycle.
- **ZERO.**
  - rsp_q = 32'hFFFFFFFF, rsp_r = latched dividend, rsp_err = 1.
  - rsp_valid = 1 in this cycle; go to IDLE.
  - The divider is not touched: no div_rst, no div_run.
- **Output hold.** rsp_q, rsp_r, rsp_id and rsp_err hold their last values until the next response. rsp_valid is a pulse with no backpressure.
- **Latency, edges counted from the acceptance edge.**
  - Normal operation: CLR, RUN, WAIT(n), DONE. rsp_valid is asserted 3+n cycles after acceptance, where n = WAIT cycles up to and including the div_rdy cycle.
  - Zero divisor: rsp_valid is asserted in the cycle right after acceptance.
- **Fairness.** With both requesters valid continuously, grants strictly alternate 0,1,0,1,…
- **Ignored inputs.** reqN inputs are ignored outside IDLE. div_q, div_r and div_rdy are ignored outside WAIT.

Test Plan:
- **Reset, then single request.** rst pulse mid-cycle, then req0 100/7 → div_rst high during rst; req0_ready for 1 cycle; one cycle each of div_rst then div_run; after the divider model raises rdy, rsp_valid = 1 with rsp_id = 0, q = 14, r = 2, err = 0.
- **Contention.** Both requesters valid from reset: req0 = 0xFFFFFFFF/0x10, req1 = 9/3 → req0 served first (q = 0x0FFFFFFF, r = 0xF), then req1 (q = 3, r = 0); the following grant returns to req0.
- **Divide-by-zero.** req1 = 0x1234/0 → rsp_valid in the cycle after acceptance; q = 0xFFFFFFFF, r = 0x1234, err = 1; div_run and div_rst stay 0.
- **Timeout.** Divider model never asserts rdy, TIMEOUT = 40 → rsp_valid with err = 2, q = r = 0, 40 WAIT cycles after div_run; next IDLE accepts a new request.
- **Reset mid-WAIT.** rst during WAIT → outputs cleared immediately and no rsp_valid; a fresh request after release completes correctly.
- **rdy on last count.** div_rdy rises in the same cycle the counter hits TIMEOUT-1 → err = 0 and the divider results are returned.
